mem_port_arbiter: RTL and testbench

Shares one single-port unified instruction/data memory between the IF stage (fetch) and the MEM stage (load/store) of the 5-stage pipeline. Each access takes LATENCY cycles. The block grants one requester at a time, latches the request and drives the memory port for the full access. It returns read data with a one-cycle done pulse and raises pipe_stall, which the hazard/stall logic ORs into its PC_write/ifid_write freeze.

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/mem_lat_counter.sv | 27 ++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM single-port memory arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    localparam logic GRANT_IF  = 1'b0;
    localparam logic GRANT_MEM = 1'b1;

    localparam int AW_DEFAULT = 32;
    localparam int DW_DEFAULT = 32;

    // Counter width able to hold LATENCY-1; never narrower than one bit.
    function automatic int cnt_width(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter timing one memory access; zero flags the final access cycle.
module mem_lat_counter #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port unified memory between fetch (IF) and load/store (MEM),
// holding the granted request on the port for LATENCY cycles and pulsing done after.
//
// state  | meaning
// IDLE   | no access in progress; arbitrate pending requests
// BUSY_I | fetch access driving the memory port
// BUSY_D | data access driving the memory port
// DONE   | done pulse for the granted requester; port idle
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int AW      = AW_DEFAULT,
    parameter int DW      = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] mem_rdata,
    output logic          mem_done,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          pipe_stall
);

    localparam int             CW       = cnt_width(LATENCY);
    localparam logic [CW-1:0]  CNT_INIT = CW'(LATENCY - 1);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic          last_grant;
    logic          grant_i;
    logic          grant_d;
    logic          cnt_zero;
    logic          busy;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          lat_we;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] mem_rdata_q;

    mem_lat_counter #(
        .W(CW)
    ) u_lat_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (grant_i | grant_d),
        .load_val (CNT_INIT),
        .dec      (busy),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // On a tie the requester not served last wins; last_grant resets to IF so D wins first.
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req && (!if_req || (last_grant == GRANT_IF))) begin
                    grant_d   = 1'b1;
                    state_nxt = BUSY_D;
                end else if (if_req) begin
                    grant_i   = 1'b1;
                    state_nxt = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (cnt_zero) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == BUSY_I) || (state == BUSY_D);
        ram_en    = busy;
        ram_we    = busy & lat_we;
        ram_addr  = busy ? lat_addr  : '0;
        ram_wdata = busy ? lat_wdata : '0;
        if_done   = (state == DONE) && (last_grant == GRANT_IF);
        mem_done  = (state == DONE) && (last_grant == GRANT_MEM);
        if_rdata  = if_rdata_q;
        mem_rdata = mem_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant  <= GRANT_IF;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_we      <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            if (grant_d) begin
                last_grant <= GRANT_MEM;
                lat_addr   <= mem_addr;
                lat_wdata  <= mem_wdata;
                lat_we     <= mem_we;
            end else if (grant_i) begin
                last_grant <= GRANT_IF;
                lat_addr   <= if_addr;
                lat_wdata  <= '0;
                lat_we     <= 1'b0;
            end
            if ((state == BUSY_I) && cnt_zero) begin
                if_rdata_q <= ram_rdata;
            end
            if ((state == BUSY_D) && cnt_zero) begin
                mem_rdata_q <= ram_rdata;
            end
        end
    end

    assign pipe_stall = (if_req & ~if_done) | (mem_req & ~mem_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table at LATENCY=2, plus a LATENCY=1 sequence.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // LATENCY=2 instance
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        pipe_stall;

    mem_port_arbiter #(.LATENCY(2), .AW(32), .DW(32)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_done    (if_done),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_done   (mem_done),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .pipe_stall (pipe_stall)
    );

    // LATENCY=1 instance
    logic        reset1;
    logic        if_req1;
    logic [31:0] if_addr1;
    logic [31:0] if_rdata1;
    logic        if_done1;
    logic        mem_req1;
    logic        mem_we1;
    logic [31:0] mem_addr1;
    logic [31:0] mem_wdata1;
    logic [31:0] mem_rdata1;
    logic        mem_done1;
    logic        ram_en1;
    logic        ram_we1;
    logic [31:0] ram_addr1;
    logic [31:0] ram_wdata1;
    logic [31:0] ram_rdata1;
    logic        pipe_stall1;

    mem_port_arbiter #(.LATENCY(1), .AW(32), .DW(32)) u_dut1 (
        .clk        (clk),
        .reset      (reset1),
        .if_req     (if_req1),
        .if_addr    (if_addr1),
        .if_rdata   (if_rdata1),
        .if_done    (if_done1),
        .mem_req    (mem_req1),
        .mem_we     (mem_we1),
        .mem_addr   (mem_addr1),
        .mem_wdata  (mem_wdata1),
        .mem_rdata  (mem_rdata1),
        .mem_done   (mem_done1),
        .ram_en     (ram_en1),
        .ram_we     (ram_we1),
        .ram_addr   (ram_addr1),
        .ram_wdata  (ram_wdata1),
        .ram_rdata  (ram_rdata1),
        .pipe_stall (pipe_stall1)
    );

    typedef struct {
        logic        rst;
        logic        ir;
        logic [31:0] ia;
        logic        mr;
        logic        mw;
        logic [31:0] ma;
        logic [31:0] md;
        logic [31:0] rr;
        logic        e_en;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic        e_ifd;
        logic [31:0] e_ifr;
        logic        e_md;
        logic [31:0] e_mr;
        logic        mr_dc;
        logic        e_st;
    } vec_t;

    vec_t vq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic add(
        input logic rst, input logic ir, input logic [31:0] ia,
        input logic mr, input logic mw, input logic [31:0] ma, input logic [31:0] md,
        input logic [31:0] rr,
        input logic en, input logic we, input logic [31:0] addr, input logic [31:0] wd,
        input logic ifd, input logic [31:0] ifr, input logic mdn, input logic [31:0] mrd,
        input logic dc, input logic st);
        vec_t v;
        v.rst = rst; v.ir = ir; v.ia = ia; v.mr = mr; v.mw = mw; v.ma = ma; v.md = md; v.rr = rr;
        v.e_en = en; v.e_we = we; v.e_addr = addr; v.e_wd = wd; v.e_ifd = ifd; v.e_ifr = ifr;
        v.e_md = mdn; v.e_mr = mrd; v.mr_dc = dc; v.e_st = st;
        vq.push_back(v);
    endtask

    initial begin
        logic ok;
        logic e_en1;
        logic e_done1;
        logic [31:0] e_addr1;
        logic [31:0] e_rd1;

        reset = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
        mem_addr = '0; mem_wdata = '0; ram_rdata = '0;
        reset1 = 1'b1; if_req1 = 1'b0; if_addr1 = '0; mem_req1 = 1'b0; mem_we1 = 1'b0;
        mem_addr1 = '0; mem_wdata1 = '0; ram_rdata1 = '0;

        //  rst   ir    ia        mr    mw    ma        md             rr              en    we    addr      wd             ifd   ifr            md    mr             dc    st
        // reset values
        add(1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,         32'h0,          1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0);
        // both request after reset: D first, then I
        add(1'b0, 1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0,        32'h0,          1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1);
        add(1'b0, 1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0,        32'h0,          1'b1, 1'b0, 32'h100, 32'h0,        1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1);
        add(1'b0, 1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0,        32'hA5A5_0001,  1'b1, 1'b0, 32'h100, 32'h0,        1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1);
        add(1'b0, 1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0,        32'h0,          1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 32'h0,         1'b1, 32'hA5A5_0001, 1'b0, 1'b1);
        add(1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0,  32'h0,         32'h0,          1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 32'h0,         1'b0, 32'hA5A5_0001, 1'b0, 1'b1);
        add(1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0,  32'h0,         32'h0,          1'b1, 1'b0, 32'h44, 32'h0,         1'b0, 32'h0,         1'b0, 32'hA5A5_0001, 1'b0, 1'b1);
        add(1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0,  32'h0,         32'h13,         1'b1, 1'b0, 32'h44, 32'h0,         1'b0, 32'h0,         1'b0, 32'hA5A5_0001, 1'b0, 1'b1);
        add(1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0,  32'h0,         32'h0,          1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 32'h13,        1'b0, 32'hA5A5_0001, 1'b0, 1'b0);
        // lone fetch
        add(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0,  32'h0,         32'h0,          1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 32'h13,        1'b0, 32'hA5A5_0001, 1'b0, 1'b1);
        add(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0,  32'h0,         32'h0,          1'b1, 1'b0, 32'h40, 32'h0,         1'b0, 32'h13,        1'b0, 32'hA5A5_0001, 1'b0, 1'b1);
        add(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0,  32'h0,         32'h0010_0093,  1'b1, 1'b0, 32'h40, 32'h0,         1'b0, 32'h13,        1'b0, 32'hA5A5_0001, 1'b0, 1'b1);
        add(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0,  32'h0,         32'h0,          1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 32'h0010_0093, 1'b0, 32'hA5A5_0001, 1'b0, 1'b0);
        // store, with address/data changed mid-access
        add(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 32'h0,          1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 32'h0010_0093, 1'b0, 32'hA5A5_0001, 1'b0, 1'b1);
        add(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h300, 32'hDEAD_BEEF, 32'h0,          1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 1'b0, 32'h0010_0093, 1'b0, 32'hA5A5_0001, 1'b0, 1'b1);
        add(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h300, 32'h1234_5678, 32'h0,          1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 1'b0, 32'h0010_0093, 1'b0, 32'hA5A5_0001, 1'b0, 1'b1);
        add(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h300, 32'h1234_5678, 32'h0,          1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 32'h0010_0093, 1'b1, 32'h0,         1'b1, 1'b0);
        add(1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,         32'h0,          1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 32'h0010_0093, 1'b0, 32'h0,         1'b1, 1'b0);
        // load, reset in second BUSY cycle, then tie must go to D again
        add(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h104, 32'h0,        32'h0,          1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 32'h0010_0093, 1'b0, 32'h0,         1'b1, 1'b1);
        add(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h104, 32'h0,        32'h0,          1'b1, 1'b0, 32'h104, 32'h0,        1'b0, 32'h0010_0093, 1'b0, 32'h0,         1'b1, 1'b1);
        add(1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 32'h104, 32'h0,        32'hFFFF_FFFF,  1'b1, 1'b0, 32'h104, 32'h0,        1'b0, 32'h0010_0093, 1'b0, 32'h0,         1'b1, 1'b1);
        add(1'b0, 1'b1, 32'h48, 1'b1, 1'b0, 32'h108, 32'h0,        32'h0,          1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1);
        add(1'b0, 1'b1, 32'h48, 1'b1, 1'b0, 32'h108, 32'h0,        32'h0,          1'b1, 1'b0, 32'h108, 32'h0,        1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1);
        add(1'b0, 1'b1, 32'h48, 1'b1, 1'b0, 32'h108, 32'h0,        32'h0BAD_F00D,  1'b1, 1'b0, 32'h108, 32'h0,        1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1);
        add(1'b0, 1'b1, 32'h48, 1'b1, 1'b0, 32'h108, 32'h0,        32'h0,          1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 32'h0,         1'b1, 32'h0BAD_F00D, 1'b0, 1'b1);
        add(1'b0, 1'b1, 32'h48, 1'b0, 1'b0, 32'h0,  32'h0,         32'h0,          1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 32'h0,         1'b0, 32'h0BAD_F00D, 1'b0, 1'b1);
        add(1'b0, 1'b1, 32'h48, 1'b0, 1'b0, 32'h0,  32'h0,         32'h0,          1'b1, 1'b0, 32'h48, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0BAD_F00D, 1'b0, 1'b1);
        add(1'b0, 1'b1, 32'h48, 1'b0, 1'b0, 32'h0,  32'h0,         32'h73,         1'b1, 1'b0, 32'h48, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0BAD_F00D, 1'b0, 1'b1);
        add(1'b0, 1'b1, 32'h48, 1'b0, 1'b0, 32'h0,  32'h0,         32'h0,          1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 32'h73,        1'b0, 32'h0BAD_F00D, 1'b0, 1'b0);
        add(1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,         32'h0,          1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 32'h73,        1'b0, 32'h0BAD_F00D, 1'b0, 1'b0);

        repeat (2) @(posedge clk);

        foreach (vq[i]) begin
            #1;
            reset = vq[i].rst; if_req = vq[i].ir; if_addr = vq[i].ia;
            mem_req = vq[i].mr; mem_we = vq[i].mw; mem_addr = vq[i].ma;
            mem_wdata = vq[i].md; ram_rdata = vq[i].rr;
            @(negedge clk);
            ok = (ram_en === vq[i].e_en) && (ram_we === vq[i].e_we) &&
                 (ram_addr === vq[i].e_addr) && (ram_wdata === vq[i].e_wd) &&
                 (if_done === vq[i].e_ifd) && (if_rdata === vq[i].e_ifr) &&
                 (mem_done === vq[i].e_md) && (vq[i].mr_dc || (mem_rdata === vq[i].e_mr)) &&
                 (pipe_stall === vq[i].e_st);
            n_cmp++;
            if (!ok) begin
                n_fail++;
                $display("FAIL vec%0d got en=%b we=%b addr=%h wd=%h ifd=%b ifr=%h md=%b mr=%h st=%b want en=%b we=%b addr=%h wd=%h ifd=%b ifr=%h md=%b mr=%h(dc=%b) st=%b",
                         i, ram_en, ram_we, ram_addr, ram_wdata, if_done, if_rdata, mem_done, mem_rdata, pipe_stall,
                         vq[i].e_en, vq[i].e_we, vq[i].e_addr, vq[i].e_wd, vq[i].e_ifd, vq[i].e_ifr,
                         vq[i].e_md, vq[i].e_mr, vq[i].mr_dc, vq[i].e_st);
            end
            @(posedge clk);
        end

        // LATENCY=1: held fetch request gives grant / BUSY / DONE every 3 cycles
        #1;
        reset1 = 1'b0; if_req1 = 1'b1; if_addr1 = 32'h80; ram_rdata1 = 32'h0000_0011;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            e_en1   = ((i % 3) == 1);
            e_done1 = ((i % 3) == 2);
            e_addr1 = e_en1 ? 32'h80 : 32'h0;
            e_rd1   = (i >= 2) ? 32'h0000_0011 : 32'h0;
            n_cmp++;
            if ((ram_en1 !== e_en1) || (ram_addr1 !== e_addr1) || (if_done1 !== e_done1) ||
                (if_rdata1 !== e_rd1) || (pipe_stall1 !== !e_done1) || (mem_done1 !== 1'b0)) begin
                n_fail++;
                $display("FAIL lat1_cyc%0d got en=%b addr=%h ifd=%b ifr=%h st=%b md=%b want en=%b addr=%h ifd=%b ifr=%h st=%b md=0",
                         i, ram_en1, ram_addr1, if_done1, if_rdata1, pipe_stall1, mem_done1,
                         e_en1, e_addr1, e_done1, e_rd1, !e_done1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
